// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, raster phase enumeration and helpers.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned DEF_X_WIDTH = 10;
    localparam int unsigned DEF_Y_WIDTH = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    // Phase order along one axis; BP wraps back to ACTIVE.
    function automatic phase_e phase_next(input phase_e p);
        case (p)
            PH_ACTIVE: return PH_FP;
            PH_FP:     return PH_SYNC;
            PH_SYNC:   return PH_BP;
            default:   return PH_ACTIVE;
        endcase
    endfunction

    // Last counter value belonging to phase p.
    function automatic int unsigned phase_last(input phase_e p,
                                               input int unsigned act,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        case (p)
            PH_ACTIVE: return act - 1;
            PH_FP:     return act + fp - 1;
            PH_SYNC:   return act + fp + sync - 1;
            default:   return act + fp + sync + bp - 1;
        endcase
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate clock-enable divider: one registered tick every CLK_DIV clocks.
module vga_pix_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Count while enabled; the tick register goes high after the edge where the count wraps.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en_i) begin
            tick_d = (cnt_q == LAST);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, H/V counters with phase FSMs, registered outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned X_WIDTH  = DEF_X_WIDTH,
    parameter int unsigned Y_WIDTH  = DEF_Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    output logic               pix_tick_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic [X_WIDTH-1:0] x_o,
    output logic [Y_WIDTH-1:0] y_o,
    output logic               line_start_o,
    output logic               frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [X_WIDTH-1:0] H_LAST = X_WIDTH'(H_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] V_LAST = Y_WIDTH'(V_TOTAL - 1);

    logic               tick;
    logic [X_WIDTH-1:0] h_q, h_d;
    logic [Y_WIDTH-1:0] v_q, v_d;
    phase_e             hph_q, hph_d, vph_q, vph_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic               ls_q, ls_d, fs_q, fs_d;

    vga_pix_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .tick_o (tick)
    );

    // Advance counters and phase FSMs on each tick; disable snaps back to the idle position.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        hph_d = hph_q;
        vph_d = vph_q;
        if (!en_i) begin
            h_d   = H_LAST;
            v_d   = V_LAST;
            hph_d = PH_BP;
            vph_d = PH_BP;
        end else if (tick) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
            if (h_q == X_WIDTH'(phase_last(hph_q, H_ACTIVE, H_FP, H_SYNC, H_BP)))
                hph_d = phase_next(hph_q);
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                if (v_q == Y_WIDTH'(phase_last(vph_q, V_ACTIVE, V_FP, V_SYNC, V_BP)))
                    vph_d = phase_next(vph_q);
            end
        end
    end

    // Output decode from the next phase so syncs/DE register together with the coordinates.
    always_comb begin
        hsync_d = (hph_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (vph_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        de_d    = en_i && (hph_d == PH_ACTIVE) && (vph_d == PH_ACTIVE);
        ls_d    = en_i && tick && (h_d == '0);
        fs_d    = ls_d && (v_d == '0);
    end

    // Position, phase and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            hph_q   <= PH_BP;
            vph_q   <= PH_BP;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hph_q   <= hph_d;
            vph_q   <= vph_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign pix_tick_o    = tick;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = h_q;
    assign y_o           = v_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-timing instance and a tiny-raster instance.
module tb_vga_timing_gen;

    typedef struct {
        int unsigned ha, hfp, hs, hbp, va, vfp, vs, vbp, d;
        bit          pol;
    } cfg_t;

    typedef struct packed {
        logic        tick, hs, vs, de, ls, fs;
        logic [15:0] x, y;
    } obs_t;

    cfg_t cfg0 = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0};
    cfg_t cfg1 = '{16, 2, 3, 4, 6, 1, 2, 2, 1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, en0, rst_n1, en1;
    logic       tk0, hs0, vs0, de0, ls0, fs0;
    logic       tk1, hs1, vs1, de1, ls1, fs1;
    logic [9:0] x0, y0, x1, y1;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned e0 = 0, e1 = 0;
    bit          run0 = 0, run1 = 0;
    obs_t        q0[$], q1[$];
    obs_t        a0, a1, ex0, ex1;

    vga_timing_gen u0 (
        .clk(clk), .rst_n(rst_n0), .en_i(en0), .pix_tick_o(tk0), .hsync_o(hs0),
        .vsync_o(vs0), .de_o(de0), .x_o(x0), .y_o(y0), .line_start_o(ls0),
        .frame_start_o(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .CLK_DIV(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n1), .en_i(en1), .pix_tick_o(tk1), .hsync_o(hs1),
        .vsync_o(vs1), .de_o(de1), .x_o(x1), .y_o(y1), .line_start_o(ls1),
        .frame_start_o(fs1)
    );

    // Expected outputs after e consecutive enabled edges, from raster arithmetic alone.
    function automatic obs_t model(input cfg_t c, input int unsigned e);
        obs_t        r;
        int unsigned ht, vt, p, l, x, y;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        p  = (e == 0) ? 0 : (e - 1) / c.d;
        if (p == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            l = p - 1;
            x = l % ht;
            y = (l / ht) % vt;
        end
        r.tick = (e > 0) && (e % c.d == 0);
        r.hs   = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? c.pol : !c.pol;
        r.vs   = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? c.pol : !c.pol;
        r.de   = (p > 0) && (x < c.ha) && (y < c.va);
        r.ls   = (e >= 2) && ((e - 1) % c.d == 0) && (x == 0);
        r.fs   = r.ls && (y == 0);
        r.x    = 16'(x);
        r.y    = 16'(y);
        return r;
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got tick=%0b hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d, want tick=%0b hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d",
                     nm, $time, act.tick, act.hs, act.vs, act.de, act.ls, act.fs, act.x, act.y,
                     exp.tick, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y);
        end
    endtask

    function automatic obs_t obs0();
        return '{tk0, hs0, vs0, de0, ls0, fs0, 16'(x0), 16'(y0)};
    endfunction

    function automatic obs_t obs1();
        return '{tk1, hs1, vs1, de1, ls1, fs1, 16'(x1), 16'(y1)};
    endfunction

    // Stimulus: inputs change at negedge, expectation for the coming posedge is queued.
    task automatic step0(input logic en, input logic rst);
        @(negedge clk);
        en0    = en;
        rst_n0 = rst;
        e0     = (!rst || !en) ? 0 : e0 + 1;
        q0.push_back(model(cfg0, e0));
        run0 = 1;
    endtask

    task automatic step1(input logic en, input logic rst);
        @(negedge clk);
        en1    = en;
        rst_n1 = rst;
        e1     = (!rst || !en) ? 0 : e1 + 1;
        q1.push_back(model(cfg1, e1));
        run1 = 1;
    endtask

    // Monitors: pop and compare once the outputs have settled after each edge.
    always @(posedge clk) begin
        #1;
        if (run0) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL u0 scoreboard: got empty queue, want an expectation");
            end else begin
                ex0 = q0.pop_front();
                a0  = obs0();
                check("u0 raster", a0, ex0);
            end
        end
        if (run1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL u1 scoreboard: got empty queue, want an expectation");
            end else begin
                ex1 = q1.pop_front();
                a1  = obs1();
                check("u1 raster", a1, ex1);
            end
        end
    end

    task automatic stim0();
        int unsigned guard;
        int unsigned len;
        logic        v;
        repeat (3) step0(1'b0, 1'b0);
        repeat (5) step0(1'b0, 1'b1);
        repeat (3 * 3200 + $urandom_range(0, 400)) step0(1'b1, 1'b1);
        for (int s = 0; s < 25; s++) begin
            len = $urandom_range(1, 60);
            v   = ($urandom_range(0, 3) != 0);
            repeat (len) step0(v, 1'b1);
        end
        guard = 0;
        step0(1'b1, 1'b1);
        while (model(cfg0, e0).hs != cfg0.pol && guard < 8000) begin
            step0(1'b1, 1'b1);
            guard++;
        end
        repeat ($urandom_range(0, 300)) step0(1'b1, 1'b1);
        // Asynchronous reset in the middle of hsync, observed before any clock edge.
        @(posedge clk);
        #3;
        rst_n0 = 1'b0;
        #1;
        check("u0 async reset", obs0(), model(cfg0, 0));
        repeat (3) step0(1'b1, 1'b0);
        repeat (4000) step0(1'b1, 1'b1);
        @(posedge clk);
        #2;
        run0 = 0;
    endtask

    task automatic stim1();
        int unsigned len;
        logic        v;
        repeat (2) step1(1'b0, 1'b0);
        repeat (3) step1(1'b0, 1'b1);
        repeat (3 * 275 + 50) step1(1'b1, 1'b1);
        for (int s = 0; s < 40; s++) begin
            len = $urandom_range(1, 120);
            v   = ($urandom_range(0, 2) != 0);
            repeat (len) step1(v, 1'b1);
        end
        repeat (1500) step1(1'b1, 1'b1);
        @(posedge clk);
        #2;
        run1 = 0;
    endtask

    initial begin
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        en0    = 1'b0;
        en1    = 1'b0;
        fork
            stim0();
            stim1();
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
